// File: rtl/layer_write_arbiter.sv
// Round-robin arbiter for the shared draw-layer write port, plus a full-layer clear sequencer
// that is built only when LAYER_ARB_CLEAR_EN is defined.
`ifndef COLOR_WIDTH
`define COLOR_WIDTH 4
`endif
`ifndef COLOR_NONE
`define COLOR_NONE {(`COLOR_WIDTH){1'b1}}
`endif

module layer_write_arbiter #(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_LAYERS = 4,
    localparam int unsigned XW = $clog2(WIDTH),
    localparam int unsigned YW = $clog2(HEIGHT),
    localparam int unsigned LW = $clog2(NUM_LAYERS),
    localparam int unsigned CW = `COLOR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*XW-1:0] req_x,
    input  logic [NUM_REQ*YW-1:0] req_y,
    input  logic [NUM_REQ*LW-1:0] req_layer,
    input  logic [NUM_REQ*CW-1:0] req_color,
    input  logic                  clear_start,
    input  logic [LW-1:0]         clear_layer,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  wr_en,
    output logic [LW-1:0]         wr_layer,
    output logic [XW-1:0]         wr_x,
    output logic [YW-1:0]         wr_y,
    output logic [CW-1:0]         wr_color
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    typedef enum logic {StArb, StClear} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic [LW-1:0] clr_layer_q, clr_layer_d;
    logic          wr_en_q, wr_en_d;
    logic [LW-1:0] wr_layer_q, wr_layer_d;
    logic [XW-1:0] wr_x_q, wr_x_d;
    logic [YW-1:0] wr_y_q, wr_y_d;
    logic [CW-1:0] wr_color_q, wr_color_d;

    logic          clear_go;
    logic [LW-1:0] clear_layer_in;
    logic          in_clear;
    logic          clear_last;
    logic          found;

    assign clear_last = (32'(cx_q) == WIDTH - 1) && (32'(cy_q) == HEIGHT - 1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        clr_layer_d = clr_layer_q;
        wr_en_d     = 1'b0;
        wr_layer_d  = wr_layer_q;
        wr_x_d      = wr_x_q;
        wr_y_d      = wr_y_q;
        wr_color_d  = wr_color_q;
        req_ready   = '0;
        found       = 1'b0;
        unique case (state_q)
            StArb: begin
                if (clear_go) begin
                    state_d     = StClear;
                    cx_d        = '0;
                    cy_d        = '0;
                    clr_layer_d = clear_layer_in;
                end else begin
                    // Search at/after the pointer first, then wrap to the indices below it.
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (!found && req_valid[i] && i >= 32'(ptr_q)) begin
                            found        = 1'b1;
                            req_ready[i] = 1'b1;
                        end
                    end
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (!found && req_valid[i]) begin
                            found        = 1'b1;
                            req_ready[i] = 1'b1;
                        end
                    end
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (req_ready[i]) begin
                            ptr_d      = IW'((i + 1) % NUM_REQ);
                            wr_x_d     = req_x[i*XW +: XW];
                            wr_y_d     = req_y[i*YW +: YW];
                            wr_layer_d = req_layer[i*LW +: LW];
                            wr_color_d = req_color[i*CW +: CW];
                            // Out-of-range targets are still granted but never written.
                            wr_en_d    = (32'(req_x[i*XW +: XW]) < WIDTH)
                                      && (32'(req_y[i*YW +: YW]) < HEIGHT)
                                      && (32'(req_layer[i*LW +: LW]) < NUM_LAYERS);
                        end
                    end
                end
            end
            StClear: begin
                if (clear_last) begin
                    state_d = StArb;
                end else if (32'(cx_q) == WIDTH - 1) begin
                    cx_d = '0;
                    cy_d = cy_q + 1'b1;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StArb;
            ptr_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            clr_layer_q <= '0;
            wr_en_q     <= 1'b0;
            wr_layer_q  <= '0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            wr_color_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            clr_layer_q <= clr_layer_d;
            wr_en_q     <= wr_en_d;
            wr_layer_q  <= wr_layer_d;
            wr_x_q      <= wr_x_d;
            wr_y_q      <= wr_y_d;
            wr_color_q  <= wr_color_d;
        end
    end

`ifdef LAYER_ARB_CLEAR_EN
    assign clear_go       = clear_start;
    assign clear_layer_in = clear_layer;
    assign in_clear       = (state_q == StClear);
    assign clear_busy     = in_clear;
    assign clear_done     = in_clear && clear_last;
`else
    logic unused_clear;
    assign unused_clear   = clear_start ^ (^clear_layer);
    assign clear_go       = 1'b0;
    assign clear_layer_in = '0;
    assign in_clear       = 1'b0;
    assign clear_busy     = 1'b0;
    assign clear_done     = 1'b0;
`endif

    // The clear sweep drives the port straight from its counters.
    assign wr_en    = in_clear | wr_en_q;
    assign wr_layer = in_clear ? clr_layer_q : wr_layer_q;
    assign wr_x     = in_clear ? cx_q : wr_x_q;
    assign wr_y     = in_clear ? cy_q : wr_y_q;
    assign wr_color = in_clear ? CW'(`COLOR_NONE) : wr_color_q;

endmodule

// File: tb/tb_layer_write_arbiter.sv
// Directed bench for layer_write_arbiter; a second instance with a narrower frame and fewer
// layers exercises the dropped-write path for out-of-range targets.
`ifndef COLOR_WIDTH
`define COLOR_WIDTH 4
`endif
`ifndef COLOR_NONE
`define COLOR_NONE {(`COLOR_WIDTH){1'b1}}
`endif

module tb_layer_write_arbiter;
    localparam int XW = 2;
    localparam int YW = 1;
    localparam int LW = 2;
    localparam int CW = `COLOR_WIDTH;
    localparam logic [CW-1:0] CNONE = `COLOR_NONE;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      req_valid;
    logic [3*XW-1:0] req_x;
    logic [3*YW-1:0] req_y;
    logic [3*LW-1:0] req_layer;
    logic [3*CW-1:0] req_color;
    logic            clear_start;
    logic [LW-1:0]   clear_layer;

    logic [2:0] req_ready, req_ready2;
    logic clear_busy, clear_done, wr_en, clear_busy2, clear_done2, wr_en2;
    logic [LW-1:0] wr_layer, wr_layer2;
    logic [XW-1:0] wr_x, wr_x2;
    logic [YW-1:0] wr_y, wr_y2;
    logic [CW-1:0] wr_color, wr_color2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    layer_write_arbiter #(.WIDTH(4), .HEIGHT(2), .NUM_REQ(3), .NUM_LAYERS(4)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_layer(req_layer), .req_color(req_color),
        .clear_start(clear_start), .clear_layer(clear_layer), .clear_busy(clear_busy),
        .clear_done(clear_done), .wr_en(wr_en), .wr_layer(wr_layer), .wr_x(wr_x),
        .wr_y(wr_y), .wr_color(wr_color)
    );

    layer_write_arbiter #(.WIDTH(3), .HEIGHT(2), .NUM_REQ(3), .NUM_LAYERS(3)) u_dut_oor (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
        .req_x(req_x), .req_y(req_y), .req_layer(req_layer), .req_color(req_color),
        .clear_start(clear_start), .clear_layer(clear_layer), .clear_busy(clear_busy2),
        .clear_done(clear_done2), .wr_en(wr_en2), .wr_layer(wr_layer2), .wr_x(wr_x2),
        .wr_y(wr_y2), .wr_color(wr_color2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_layer = '0;
        req_color = '0;
    endtask

    task automatic set_req(input int i, input int x, input int y, input int l, input int c);
        req_valid[i]          = 1'b1;
        req_x[i*XW +: XW]     = XW'(x);
        req_y[i*YW +: YW]     = YW'(y);
        req_layer[i*LW +: LW] = LW'(l);
        req_color[i*CW +: CW] = CW'(c);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        clear_start = 1'b0;
        clr_req();
        next();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        clear_start = 1'b0;
        clear_layer = '0;
        clr_req();
        next();
        next();
        #2;
        check("rst_wr_en", wr_en, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", clear_busy, 0);
        check("rst_done", clear_done, 0);
        check("rst_wr_x", wr_x, 0);
        check("rst_wr_color", wr_color, 0);
        reset = 1'b0;
        next();

        // Single requester: grant now, write one cycle later, then idle.
        set_req(1, 2, 1, 3, 5);
        #2;
        check("t1_ready", req_ready, 3'b010);
        next();
        clr_req();
        #2;
        check("t1_wr_en", wr_en, 1);
        check("t1_wr_x", wr_x, 2);
        check("t1_wr_y", wr_y, 1);
        check("t1_wr_layer", wr_layer, 3);
        check("t1_wr_color", wr_color, 5);
        next();
        #2;
        check("t1_wr_en_idle", wr_en, 0);

        // All three valid: strict rotation 0,1,2,0,1,2 with back-to-back writes.
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, i, i % 2, i, 8 + i);
        for (int k = 0; k < 6; k++) begin
            #2;
            check("t2_ready", req_ready, 32'(1) << (k % 3));
            if (k > 0) begin
                check("t2_wr_en", wr_en, 1);
                check("t2_wr_color", wr_color, 8 + ((k - 1) % 3));
            end
            next();
        end
        clr_req();
        #2;
        check("t2_wr_en_last", wr_en, 1);
        check("t2_wr_color_last", wr_color, 10);
        next();
        #2;
        check("t2_wr_en_idle", wr_en, 0);

        // Out of range on the narrow instance: req0 x=3 >= 3, req2 layer=3 >= 3.
        do_reset();
        set_req(0, 3, 0, 0, 1);
        set_req(1, 1, 1, 1, 2);
        set_req(2, 0, 1, 3, 3);
        #2;
        check("t5_ready_a", req_ready, 3'b001);
        check("t5_ready2_a", req_ready2, 3'b001);
        next();
        #2;
        check("t5_ready2_b", req_ready2, 3'b010);
        check("t5_wr_en_b", wr_en, 1);
        check("t5_wr_x_b", wr_x, 3);
        check("t5_wr_en2_b", wr_en2, 0);
        next();
        #2;
        check("t5_ready2_c", req_ready2, 3'b100);
        check("t5_wr_en2_c", wr_en2, 1);
        check("t5_wr_x2_c", wr_x2, 1);
        check("t5_wr_y2_c", wr_y2, 1);
        check("t5_wr_layer2_c", wr_layer2, 1);
        check("t5_wr_color2_c", wr_color2, 2);
        next();
        clr_req();
        #2;
        check("t5_wr_en_d", wr_en, 1);
        check("t5_wr_layer_d", wr_layer, 3);
        check("t5_wr_en2_d", wr_en2, 0);
        next();
        #2;
        check("t5_wr_en_idle", wr_en, 0);

`ifdef LAYER_ARB_CLEAR_EN
        // Clear of layer 2 beats a simultaneous request; a restart mid-sweep is ignored.
        do_reset();
        set_req(0, 1, 0, 1, 7);
        clear_start = 1'b1;
        clear_layer = 2'd2;
        #2;
        check("t3_ready_start", req_ready, 0);
        check("t3_busy_start", clear_busy, 0);
        next();
        clear_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) clear_start = 1'b0;
            #2;
            check("t3_wr_en", wr_en, 1);
            check("t3_wr_x", wr_x, (k - 1) % 4);
            check("t3_wr_y", wr_y, (k - 1) / 4);
            check("t3_wr_layer", wr_layer, 2);
            check("t3_wr_color", wr_color, CNONE);
            check("t3_busy", clear_busy, 1);
            check("t3_done", clear_done, (k == 8) ? 1 : 0);
            check("t3_ready", req_ready, 0);
            if (k == 3) begin
                clear_start = 1'b1;
                clear_layer = 2'd0;
            end
            next();
        end
        #2;
        check("t3_ready_after", req_ready, 3'b001);
        check("t3_busy_after", clear_busy, 0);
        check("t3_done_after", clear_done, 0);
        check("t3_wr_en_after", wr_en, 0);
        next();
        clr_req();
        #2;
        check("t3_wr_en_req", wr_en, 1);
        check("t3_wr_color_req", wr_color, 7);

        // Reset in the middle of a clear aborts it with no done pulse.
        do_reset();
        clear_start = 1'b1;
        clear_layer = 2'd1;
        next();
        clear_start = 1'b0;
        #2;
        check("t4_busy_1", clear_busy, 1);
        next();
        next();
        reset = 1'b1;
        #2;
        check("t4_busy_3", clear_busy, 1);
        check("t4_wr_x_3", wr_x, 2);
        next();
        reset = 1'b0;
        set_req(2, 3, 1, 0, 4);
        #2;
        check("t4_busy_4", clear_busy, 0);
        check("t4_wr_en_4", wr_en, 0);
        check("t4_done_4", clear_done, 0);
        check("t4_ready_4", req_ready, 3'b100);
        next();
        clr_req();
        for (int k = 5; k <= 8; k++) begin
            #2;
            if (k == 5) begin
                check("t4_wr_en_5", wr_en, 1);
                check("t4_wr_color_5", wr_color, 4);
            end
            check("t4_done_quiet", clear_done, 0);
            check("t4_busy_quiet", clear_busy, 0);
            next();
        end
`else
        // Without the clear engine, clear_start has no effect on arbitration.
        do_reset();
        set_req(1, 2, 0, 1, 6);
        clear_start = 1'b1;
        clear_layer = 2'd2;
        #2;
        check("t6_ready", req_ready, 3'b010);
        check("t6_busy", clear_busy, 0);
        next();
        clr_req();
        #2;
        check("t6_wr_en", wr_en, 1);
        check("t6_wr_x", wr_x, 2);
        check("t6_wr_color", wr_color, 6);
        for (int k = 0; k < 4; k++) begin
            clear_start = (k % 2 == 0);
            next();
            #2;
            check("t6_busy_quiet", clear_busy, 0);
            check("t6_done_quiet", clear_done, 0);
            check("t6_wr_en_quiet", wr_en, 0);
        end
        clear_start = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
